eth_rx_gearbox: RTL and testbench
=================================

# eth_rx_gearbox

Receive-side 64b/66b gearbox between the transceiver parallel RX data port and the block-lock FSM. Accumulates raw IN_W-bit words from the transceiver, which runs with its internal gearbox bypassed, into 66-bit blocks. Presents each block's 2-bit sync header and 64-bit payload with a one-cycle valid strobe. Implements the RX slip request from the block-lock FSM by discarding exactly one received bit per slip pulse, which moves the block boundary by one bit.

## Interface
- IN_W, 32, transceiver word width; legal values 16, 32, 64.
- i_clk  in  1  RX recovered/user clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_data  in  IN_W  raw received bits; i_data[0] is the earliest bit on the wire.
- i_data_valid  in  1  i_data carries IN_W new bits this cycle.
- i_rxslip  in  1  single-cycle pulse from the block-lock FSM: discard one bit.
- o_header  out  2  sync header; o_header[0] is the first bit of the block, o_header[1] the second.
- o_data  out  64  payload; o_data[0] is the third bit of the block.
- o_valid  out  1  o_header/o_data hold a new block this cycle; this strobe drives the lock FSM header-valid input.

## Operation
- State:
  - bit buffer BUF, width 65+IN_W.
  - fill count CNT, width clog2(66+IN_W); invariant 0..65 between edges.
  - slip-pending flag SP.
- Per rising edge, evaluated in this order on registered values:
  1. Slip. Let S = SP | i_rxslip. If S and CNT>0: BUF=BUF>>1, CNT=CNT-1, SP<=0. If S and CNT==0: SP<=1 and nothing is discarded.
  2. Append. If i_data_valid: BUF |= i_data << CNT, CNT += IN_W.
  3. Emit. If CNT>=66: {o_data,o_header} <= BUF[65:0], o_valid<=1, BUF>>=66, CNT-=66. Otherwise o_valid<=0, and o_header/o_data hold their last value.
- At most one block is emitted per cycle. Max CNT before emit is 65+IN_W, and after emit it is ≤ IN_W-1, so no overflow is possible.
- A slip pulse arriving while SP=1 merges with the pending slip: one bit is discarded, not two.
- Slip and append in the same cycle: the discarded bit is the oldest buffered bit. The incoming word is never the source of the discarded bit unless CNT was 0, in which case the slip stays pending and takes i_data[0] on the next edge.
- Bits above CNT in BUF are always zero. Shifts fill with zero.
- Rate: for IN_W=32, 33 valid words yield exactly 16 blocks with CNT returning to its starting value.
- No header checking happens here. Header validity belongs to the lock FSM.

## Timing
- Reset (asynchronous assert, synchronous release by the clock domain): o_valid=0, o_header=2'b00, o_data=0, CNT=0, BUF=0, SP=0.
- Reset mid-operation discards all buffered bits and any pending slip. The first word after release starts a new block at its bit 0.
- Latency: o_valid rises on the edge that clocks in the word completing a block, so it is high in the cycle after that word is presented.
- IN_W=32 from reset with continuous valid words (words w0, w1, …):
  - first o_valid in the cycle after w2;
  - next blocks after w4, w6, …;
  - CNT sequence 32, 64, 30, 62, 28, …
- i_data_valid=0 freezes BUF and CNT (a pending slip may still consume one bit). o_valid is 0 that cycle.
- A slip takes effect on the edge where it is seen. The first block affected is the next one emitted.
- The slip input has no minimum spacing requirement. The lock FSM spaces pulses by ≥4 cycles.

## Test plan
- Reset: hold i_rst 3 cycles with random i_data and valid=1. Required: o_valid=0, o_header=0, o_data=0 throughout. After release, the first block equals bits 0..65 of the post-reset stream.
- Aligned stream (IN_W=32): send 33 words encoding 16 blocks with header 2'b01 and payloads 0..15. Required: 16 o_valid pulses, headers 01, payloads 0..15 in order, CNT=0 afterwards.
- Single slip: stream of blocks, then one i_rxslip pulse. Required: every subsequent block equals the reference stream offset by +1 bit. 66 pulses total restore the original boundary with exactly one block lost.
- Valid gaps: insert random i_data_valid=0 cycles, including one coinciding with i_rxslip. Required: output blocks identical to the gap-free run, minus exactly one bit at the slip point.
- Slip at empty buffer: pulse i_rxslip on the first cycle after reset with no data. Required: SP=1; the first emitted block is bits 1..66 of the stream.
- Closed loop with the block-lock FSM: a stream of valid-header blocks starting at a random bit offset 0..65. Required: block lock asserts within 66 slips plus lock-test time, and afterwards every o_header is 01 or 10.

Source files
------------

// File: rtl/eth_rx_gearbox.sv
// -----------------------------------------------------------------------------
// eth_rx_gearbox
//
// Receive-side 64b/66b gearbox. Collects raw IN_W-bit words from a transceiver
// running with its internal gearbox bypassed and cuts the bit stream into
// 66-bit blocks (2-bit sync header + 64-bit payload). A slip pulse from the
// block-lock FSM discards exactly one received bit, moving the block boundary
// by one bit.
//
// Ports:
//   i_clk         RX recovered/user clock, all logic on the rising edge
//   i_rst         asynchronous active-high reset
//   i_data        raw received bits, i_data[0] is the earliest bit on the wire
//   i_data_valid  i_data carries IN_W new bits this cycle
//   i_rxslip      single-cycle pulse: discard one bit
//   o_header      sync header, o_header[0] is the first bit of the block
//   o_data        payload, o_data[0] is the third bit of the block
//   o_valid       o_header/o_data hold a new block this cycle
// -----------------------------------------------------------------------------
module eth_rx_gearbox #(
    parameter int IN_W = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [IN_W-1:0] i_data,
    input  logic            i_data_valid,
    input  logic            i_rxslip,
    output logic [1:0]      o_header,
    output logic [63:0]     o_data,
    output logic            o_valid
);

    localparam int BUF_W = 65 + IN_W;
    localparam int CNT_W = $clog2(66 + IN_W);
    localparam logic [CNT_W-1:0] BLK_BITS  = CNT_W'(66);
    localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] ONE_BIT   = CNT_W'(1);

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sp;

    logic             w_slip;
    logic             w_slipTake;
    logic             w_spNext;
    logic [BUF_W-1:0] w_bufSlip;
    logic [BUF_W-1:0] w_bufApp;
    logic [BUF_W-1:0] w_bufNext;
    logic [CNT_W-1:0] w_cntSlip;
    logic [CNT_W-1:0] w_cntApp;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_emit;

    // Next-state datapath, evaluated as three chained steps on the registered
    // buffer: slip first (so the discarded bit is always the oldest one held),
    // then append the incoming word right above the valid bits, then cut off
    // a full block if one is available. A slip that finds the buffer empty
    // cannot discard anything yet, so it is parked in r_sp and retried on the
    // next edge; a new pulse arriving while parked simply merges with it.
    // Bits above the fill count stay zero because every shift fills with zero
    // and the append only ORs into the region at and above the fill count.
    always_comb begin
        w_slip     = r_sp | i_rxslip;
        w_slipTake = w_slip && (r_cnt != '0);
        w_spNext   = w_slip && (r_cnt == '0);

        w_bufSlip = r_buf;
        w_cntSlip = r_cnt;
        if (w_slipTake) begin
            w_bufSlip = r_buf >> 1;
            w_cntSlip = r_cnt - ONE_BIT;
        end

        w_bufApp = w_bufSlip;
        w_cntApp = w_cntSlip;
        if (i_data_valid) begin
            w_bufApp = w_bufSlip | (BUF_W'(i_data) << w_cntSlip);
            w_cntApp = w_cntSlip + WORD_BITS;
        end

        w_emit    = (w_cntApp >= BLK_BITS);
        w_bufNext = w_bufApp;
        w_cntNext = w_cntApp;
        if (w_emit) begin
            w_bufNext = w_bufApp >> 66;
            w_cntNext = w_cntApp - BLK_BITS;
        end
    end

    // State and output registers. The block outputs only load when a block is
    // cut and otherwise keep the last block, so the lock FSM can sample them
    // qualified by o_valid alone. Reset throws away all buffered bits and any
    // parked slip, so the first word after release starts a fresh block.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_buf    <= '0;
            r_cnt    <= '0;
            r_sp     <= 1'b0;
            o_valid  <= 1'b0;
            o_header <= 2'b00;
            o_data   <= '0;
        end else begin
            r_buf   <= w_bufNext;
            r_cnt   <= w_cntNext;
            r_sp    <= w_spNext;
            o_valid <= w_emit;
            if (w_emit) begin
                o_header <= w_bufApp[1:0];
                o_data   <= w_bufApp[65:2];
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_gearbox.sv
// -----------------------------------------------------------------------------
// tb_eth_rx_gearbox
//
// Self-checking bench for eth_rx_gearbox (IN_W = 32). A bit-queue reference
// model of the receive stream produces expected blocks into a scoreboard queue
// as stimulus is driven; blocks are popped and compared when the DUT presents
// them. A table of known blocks checks the aligned stream directly, and
// hand-written sequences cover reset, slip at an empty buffer, valid gaps and a
// closed-loop header search driven by the bench.
// -----------------------------------------------------------------------------
module tb_eth_rx_gearbox;

    localparam int IN_W = 32;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [IN_W-1:0] i_data;
    logic            i_data_valid;
    logic            i_rxslip;
    logic [1:0]      o_header;
    logic [63:0]     o_data;
    logic            o_valid;

    eth_rx_gearbox #(.IN_W(IN_W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .i_rxslip     (i_rxslip),
        .o_header     (o_header),
        .o_data       (o_data),
        .o_valid      (o_valid)
    );

    // Free-running 100 MHz clock.
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  hdr;
        logic [63:0] pay;
    } vec_t;

    vec_t        vecs [16];
    logic [65:0] expQ [$];
    logic [65:0] gotQ [$];
    bit          mdlBits [$];
    bit          srcBits [$];
    bit          mdlSp;
    bit          expValid;
    logic [65:0] lastExp;
    int          compared   = 0;
    int          mismatched = 0;

    // Hard time limit so the run always ends even if the DUT stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish required finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and reports actual vs required on a mismatch.
    task automatic checkVal(input string name, input logic [65:0] act, input logic [65:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%h required 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] randWord();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[IN_W-1:0];
    endfunction

    // Next word of the closed-loop source: an endless run of blocks with a
    // legal header (01 or 10) and random payload.
    function automatic logic [IN_W-1:0] nextSrcWord();
        logic [IN_W-1:0] w;
        logic [65:0]     b;
        while (srcBits.size() < IN_W) begin
            b[1:0]  = ($urandom_range(1) == 0) ? 2'b01 : 2'b10;
            b[65:2] = {$urandom(), $urandom()};
            for (int j = 0; j < 66; j++) srcBits.push_back(b[j]);
        end
        for (int j = 0; j < IN_W; j++) w[j] = srcBits.pop_front();
        return w;
    endfunction

    // Drives one cycle of inputs and advances the reference model: a bit
    // queue where a slip pops the oldest bit (or is parked when empty), a
    // valid word pushes its bits oldest first, and 66 queued bits form a block.
    task automatic applyStimulus(input logic [IN_W-1:0] d, input bit v, input bit s);
        logic [65:0] b;
        i_data       = d;
        i_data_valid = v;
        i_rxslip     = s;
        if (mdlSp || s) begin
            if (mdlBits.size() > 0) begin
                void'(mdlBits.pop_front());
                mdlSp = 1'b0;
            end else begin
                mdlSp = 1'b1;
            end
        end
        if (v) for (int j = 0; j < IN_W; j++) mdlBits.push_back(d[j]);
        expValid = 1'b0;
        if (mdlBits.size() >= 66) begin
            for (int j = 0; j < 66; j++) b[j] = mdlBits.pop_front();
            expQ.push_back(b);
            expValid = 1'b1;
        end
    endtask

    // Compares the DUT outputs one step after the edge against the model:
    // strobe, block contents when a block is due, held contents otherwise.
    task automatic checkOutput();
        logic [65:0] e;
        checkVal("valid", 66'(o_valid), 66'(expValid));
        if (o_valid) gotQ.push_back({o_data, o_header});
        if (expValid) begin
            e = expQ.pop_front();
            lastExp = e;
            if (o_valid) checkVal("block", {o_data, o_header}, e);
        end else begin
            checkVal("hold", {o_data, o_header}, lastExp);
        end
    endtask

    task automatic cycle(input logic [IN_W-1:0] d, input bit v, input bit s);
        applyStimulus(d, v, s);
        @(posedge i_clk);
        #1;
        checkOutput();
    endtask

    // Holds reset for three cycles with live random data; outputs must stay
    // cleared. The model and scoreboard restart empty on release.
    task automatic doReset();
        i_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data       = randWord();
            i_data_valid = 1'b1;
            i_rxslip     = ($urandom_range(1) == 1);
            @(posedge i_clk);
            #1;
            checkVal("reset_valid", 66'(o_valid), 66'(0));
            checkVal("reset_block", {o_data, o_header}, 66'(0));
        end
        checkVal("reset_cnt", 66'(dut.r_cnt), 66'(0));
        checkVal("reset_sp", 66'(dut.r_sp), 66'(0));
        i_rst        = 1'b0;
        i_data_valid = 1'b0;
        i_rxslip     = 1'b0;
        mdlBits.delete();
        expQ.delete();
        gotQ.delete();
        mdlSp    = 1'b0;
        expValid = 1'b0;
        lastExp  = '0;
    endtask

    initial begin
        logic [1055:0]   stream;
        logic [IN_W-1:0] w3 [3];
        logic [95:0]     s96;
        logic [65:0]     expBlk;
        int              k, slips, good, sinceSlip, nBlk;
        bit              wantSlip, doSlip;

        i_rst        = 1'b1;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_rxslip     = 1'b0;
        #1;

        // Reset, then an aligned stream of 16 known blocks in 33 words.
        doReset();
        for (int i = 0; i < 16; i++) begin
            vecs[i].hdr = 2'b01;
            vecs[i].pay = 64'(i);
        end
        for (int i = 0; i < 16; i++) stream[66*i +: 66] = {vecs[i].pay, vecs[i].hdr};
        for (int w = 0; w < 33; w++) cycle(stream[32*w +: 32], 1'b1, 1'b0);
        checkVal("aligned_count", 66'(gotQ.size()), 66'(16));
        for (int i = 0; i < 16 && i < gotQ.size(); i++) begin
            checkVal("aligned_hdr", 66'(gotQ[i][1:0]), 66'(vecs[i].hdr));
            checkVal("aligned_pay", 66'(gotQ[i][65:2]), 66'(vecs[i].pay));
        end
        checkVal("aligned_cnt", 66'(dut.r_cnt), 66'(0));

        // Single slip in a running stream, then 65 more to come full circle.
        for (int i = 0; i < 10; i++) cycle(randWord(), 1'b1, 1'b0);
        cycle(randWord(), 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(randWord(), 1'b1, 1'b0);
        for (int n = 0; n < 65; n++) begin
            cycle(randWord(), 1'b1, 1'b1);
            for (int i = 0; i < 3; i++) cycle(randWord(), 1'b1, 1'b0);
        end
        for (int i = 0; i < 20; i++) cycle(randWord(), 1'b1, 1'b0);

        // Random valid gaps with occasional slips, one slip on an idle cycle.
        doReset();
        for (int i = 0; i < 300; i++)
            cycle(randWord(), ($urandom_range(3) != 0), ($urandom_range(19) == 0));
        cycle(randWord(), 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(randWord(), 1'b1, 1'b0);

        // Slip at an empty buffer parks; a second pulse merges with it.
        doReset();
        cycle(randWord(), 1'b0, 1'b1);
        checkVal("empty_slip_sp", 66'(dut.r_sp), 66'(1));
        cycle(randWord(), 1'b0, 1'b1);
        checkVal("merged_slip_sp", 66'(dut.r_sp), 66'(1));
        checkVal("merged_slip_cnt", 66'(dut.r_cnt), 66'(0));
        for (int i = 0; i < 3; i++) begin
            w3[i] = randWord();
            cycle(w3[i], 1'b1, 1'b0);
        end
        s96    = {w3[2], w3[1], w3[0]};
        expBlk = s96[66:1];
        checkVal("empty_slip_count", 66'(gotQ.size()), 66'(1));
        if (gotQ.size() > 0) checkVal("empty_slip_block", gotQ[0], expBlk);

        // Closed loop: source starts at a random bit offset; the bench slips
        // on every bad header (spaced >= 4 cycles) until 32 good headers run.
        doReset();
        srcBits.delete();
        k = $urandom_range(65);
        for (int j = 0; j < k; j++) srcBits.push_back($urandom_range(1) == 1);
        slips = 0; good = 0; sinceSlip = 4; wantSlip = 1'b0;
        for (int c = 0; c < 3000 && good < 32; c++) begin
            doSlip = wantSlip && (sinceSlip >= 4);
            cycle(nextSrcWord(), 1'b1, doSlip);
            if (doSlip) begin
                slips++;
                wantSlip  = 1'b0;
                sinceSlip = 0;
                good      = 0;
            end else begin
                sinceSlip++;
            end
            if (o_valid) begin
                if (o_header == 2'b01 || o_header == 2'b10) good++;
                else begin
                    good     = 0;
                    wantSlip = 1'b1;
                end
            end
        end
        checkVal("lock_reached", 66'(good >= 32), 66'(1));
        checkVal("lock_slip_budget", 66'(slips <= 66), 66'(1));
        nBlk = 0;
        for (int c = 0; c < 200 && nBlk < 20; c++) begin
            cycle(nextSrcWord(), 1'b1, 1'b0);
            if (o_valid) begin
                nBlk++;
                checkVal("locked_hdr", 66'(o_header == 2'b01 || o_header == 2'b10), 66'(1));
            end
        end
        checkVal("locked_blocks", 66'(nBlk), 66'(20));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
